// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift window over a raster stream.
// Emits one window per fully-inside position; a single output slot gives valid/ready backpressure.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9*DATA_W-1:0]      out_window,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // position of the next pixel to arrive
  logic [CW-1:0] pix_col_reg, pix_col_next;
  logic [RW-1:0] pix_row_reg, pix_row_next;

  // lb0 holds the previous row, lb1 the row before that
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic [DATA_W-1:0] win_reg  [3][3];
  logic [DATA_W-1:0] win_next [3][3];
  logic [DATA_W-1:0] col_in   [3];
  logic [9*DATA_W-1:0] win_flat;

  logic                out_valid_reg, out_valid_next;
  logic [9*DATA_W-1:0] out_window_reg;
  logic [RW-1:0]       out_row_reg;
  logic [CW-1:0]       out_col_reg;

  logic in_fire, out_fire, emit;

  assign in_ready = !out_valid_reg || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;
  assign emit     = in_fire && (pix_row_reg >= RW'(2)) && (pix_col_reg >= CW'(2));

  assign lb0_rd = lb0_mem[pix_col_reg];
  assign lb1_rd = lb1_mem[pix_col_reg];

  assign col_in[0] = lb1_rd;
  assign col_in[1] = lb0_rd;
  assign col_in[2] = in_data;

  // Shift left by one column; the incoming column enters at c=2.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      assign win_next[gi][0] = win_reg[gi][1];
      assign win_next[gi][1] = win_reg[gi][2];
      assign win_next[gi][2] = col_in[gi];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_flat
      assign win_flat[gi*DATA_W +: DATA_W] = win_next[gi/3][gi%3];
    end
  endgenerate

  always_comb begin
    pix_col_next = pix_col_reg;
    pix_row_next = pix_row_reg;
    if (pix_col_reg == CW'(IMG_W-1)) begin
      pix_col_next = '0;
      if (pix_row_reg == RW'(IMG_H-1)) begin
        pix_row_next = '0;
      end else begin
        pix_row_next = pix_row_reg + RW'(1);
      end
    end else begin
      pix_col_next = pix_col_reg + CW'(1);
    end
  end

  // A fresh window wins over draining the slot, so valid stays high across back-to-back windows.
  always_comb begin
    out_valid_next = out_valid_reg;
    if (emit) begin
      out_valid_next = 1'b1;
    end else if (out_fire) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_col_reg    <= '0;
      pix_row_reg    <= '0;
      win_reg        <= '{default: '0};
      out_valid_reg  <= 1'b0;
      out_window_reg <= '0;
      out_row_reg    <= '0;
      out_col_reg    <= '0;
    end else begin
      if (in_fire) begin
        pix_col_reg <= pix_col_next;
        pix_row_reg <= pix_row_next;
        win_reg     <= win_next;
      end
      out_valid_reg <= out_valid_next;
      if (emit) begin
        out_window_reg <= win_flat;
        out_row_reg    <= pix_row_reg - RW'(2);
        out_col_reg    <= pix_col_reg - CW'(2);
      end
    end
  end

  // Line buffers carry no reset; stale content only reaches windows that are never emitted.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb1_mem[pix_col_reg] <= lb0_rd;
      lb0_mem[pix_col_reg] <= in_data;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_window = out_window_reg;
  assign out_row    = out_row_reg;
  assign out_col    = out_col_reg;
  assign frame_done = out_fire && (out_row_reg == RW'(IMG_H-3)) && (out_col_reg == CW'(IMG_W-3));

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 4x4 directed frames with stall/bubble/reset corners,
// plus a 16x16 random frame checked against a window model.
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 4x4 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
  logic [7:0]  a_in_data;
  logic [71:0] a_out_window;
  logic [1:0]  a_out_row, a_out_col;

  // 16x16 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic [7:0]  b_in_data;
  logic [71:0] b_out_window;
  logic [3:0]  b_out_row, b_out_col;

  conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_window(a_out_window), .out_row(a_out_row), .out_col(a_out_col),
    .frame_done(a_frame_done)
  );

  conv_window_gen #(.DATA_W(8), .IMG_W(16), .IMG_H(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_window(b_out_window), .out_row(b_out_row), .out_col(b_out_col),
    .frame_done(b_frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  typedef struct {
    logic [7:0]  pix;
    logic        emit;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [71:0] win;
    logic        done;
  } vec_t;

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [71:0] win;
    logic        done;
  } obs_t;

  typedef struct {
    logic [3:0]  row;
    logic [3:0]  col;
    logic [71:0] win;
  } obsb_t;

  vec_t  vt[16];
  obs_t  ef[8];
  obs_t  capq[$];
  obsb_t capb[$];
  int    fd_cnt;
  logic [7:0] img [16][16];

  // Transfers are sampled half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready)
      capq.push_back('{row: a_out_row, col: a_out_col, win: a_out_window, done: a_frame_done});
    if (a_frame_done) fd_cnt++;
    if (b_out_valid && b_out_ready)
      capb.push_back('{row: b_out_row, col: b_out_col, win: b_out_window});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    logic acc;
    a_in_valid = 1'b1;
    a_in_data  = d;
    t = 0;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", d, t);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   128'(a_in_ready),   128'(1));
    chk({tag, "_out_valid"},  128'(a_out_valid),  128'(0));
    chk({tag, "_out_window"}, 128'(a_out_window), 128'(0));
    chk({tag, "_out_row"},    128'(a_out_row),    128'(0));
    chk({tag, "_out_col"},    128'(a_out_col),    128'(0));
    chk({tag, "_frame_done"}, 128'(a_frame_done), 128'(0));
  endtask

  task automatic check_frames(input string tag, input int nexp, input int nfd);
    chk({tag, "_count"}, 128'(capq.size()), 128'(nexp));
    for (int k = 0; k < nexp && k < capq.size(); k++) begin
      chk($sformatf("%s_w%0d_pos", tag, k), 128'({capq[k].row, capq[k].col}),
          128'({ef[k].row, ef[k].col}));
      chk($sformatf("%s_w%0d_win", tag, k), 128'(capq[k].win), 128'(ef[k].win));
      chk($sformatf("%s_w%0d_done", tag, k), 128'(capq[k].done), 128'(ef[k].done));
    end
    chk({tag, "_frame_done_pulses"}, 128'(fd_cnt), 128'(nfd));
  endtask

  initial begin
    logic [71:0] held;
    logic [71:0] e;
    int t;

    // Pixel table for the 4x4 ramp: windows follow pixels 10, 11, 14 and 15.
    for (int i = 0; i < 16; i++)
      vt[i] = '{pix: 8'(i), emit: 1'b0, row: 2'd0, col: 2'd0, win: 72'd0, done: 1'b0};
    vt[10] = '{pix: 8'd10, emit: 1'b1, row: 2'd0, col: 2'd0, win: pk(0, 1, 2, 4, 5, 6, 8, 9, 10),      done: 1'b0};
    vt[11] = '{pix: 8'd11, emit: 1'b1, row: 2'd0, col: 2'd1, win: pk(1, 2, 3, 5, 6, 7, 9, 10, 11),     done: 1'b0};
    vt[14] = '{pix: 8'd14, emit: 1'b1, row: 2'd1, col: 2'd0, win: pk(4, 5, 6, 8, 9, 10, 12, 13, 14),   done: 1'b0};
    vt[15] = '{pix: 8'd15, emit: 1'b1, row: 2'd1, col: 2'd1, win: pk(5, 6, 7, 9, 10, 11, 13, 14, 15),  done: 1'b1};
    ef[0] = '{row: 2'd0, col: 2'd0, win: vt[10].win, done: 1'b0};
    ef[1] = '{row: 2'd0, col: 2'd1, win: vt[11].win, done: 1'b0};
    ef[2] = '{row: 2'd1, col: 2'd0, win: vt[14].win, done: 1'b0};
    ef[3] = '{row: 2'd1, col: 2'd1, win: vt[15].win, done: 1'b1};
    ef[4] = '{row: 2'd0, col: 2'd0, win: pk(100, 101, 102, 104, 105, 106, 108, 109, 110), done: 1'b0};
    ef[5] = '{row: 2'd0, col: 2'd1, win: pk(101, 102, 103, 105, 106, 107, 109, 110, 111), done: 1'b0};
    ef[6] = '{row: 2'd1, col: 2'd0, win: pk(104, 105, 106, 108, 109, 110, 112, 113, 114), done: 1'b0};
    ef[7] = '{row: 2'd1, col: 2'd1, win: pk(105, 106, 107, 109, 110, 111, 113, 114, 115), done: 1'b1};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b1;
    fd_cnt = 0;
    idle(3);
    check_reset("reset");
    rst_n = 1'b1;
    idle(1);

    // Test 1: plain ramp, per-pixel table check
    capq.delete(); fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(vt[i].pix);
      chk($sformatf("t1_p%0d_valid", i), 128'(a_out_valid), 128'(vt[i].emit));
      if (vt[i].emit) begin
        chk($sformatf("t1_p%0d_win", i), 128'(a_out_window), 128'(vt[i].win));
        chk($sformatf("t1_p%0d_pos", i), 128'({a_out_row, a_out_col}), 128'({vt[i].row, vt[i].col}));
      end
      chk($sformatf("t1_p%0d_done", i), 128'(a_frame_done), 128'(vt[i].done));
    end
    idle(3);
    check_frames("t1", 4, 1);

    // Test 2: hold the first window for 3 cycles
    capq.delete(); fd_cnt = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'(i));
      end
      begin
        t = 0;
        while (!a_out_valid && t < 200) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("t2_valid_seen", 128'(a_out_valid), 128'(1));
        held = a_out_window;
        chk("t2_held_first", 128'(held), 128'(ef[0].win));
        a_out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("t2_hold_win",   128'(a_out_window), 128'(held));
          chk("t2_hold_valid", 128'(a_out_valid),  128'(1));
          chk("t2_in_ready",   128'(a_in_ready),   128'(0));
        end
        a_out_ready = 1'b1;
      end
    join
    idle(3);
    check_frames("t2", 4, 1);

    // Test 3: random input bubbles
    capq.delete(); fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1) == 1) idle(1);
      send(8'(i));
    end
    idle(3);
    check_frames("t3", 4, 1);

    // Test 4: two back-to-back frames
    capq.delete(); fd_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send(8'(f * 100 + i));
    idle(3);
    check_frames("t4", 8, 2);

    // Test 5: reset after pixel 9, then a clean frame
    capq.delete(); fd_cnt = 0;
    for (int i = 0; i < 10; i++) send(8'(i));
    rst_n = 1'b0;
    idle(2);
    check_reset("t5_reset");
    rst_n = 1'b1;
    idle(1);
    chk("t5_aborted_none", 128'(capq.size()), 128'(0));
    capq.delete(); fd_cnt = 0;
    for (int i = 0; i < 16; i++) send(8'(i));
    idle(3);
    check_frames("t5", 4, 1);

    // Test 6: 16x16 random frame against a window model
    capb.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        img[r][c] = 8'($urandom_range(255));
        b_in_valid = 1'b1;
        b_in_data  = img[r][c];
        @(negedge clk);
        chk("t6_in_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        #1;
      end
    end
    b_in_valid = 1'b0;
    idle(3);
    chk("t6_count", 128'(capb.size()), 128'(196));
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 14; c++) begin
        if (r * 14 + c < capb.size()) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e[(i*3+j)*8 +: 8] = img[r+i][c+j];
          chk($sformatf("t6_w%0d_pos", r * 14 + c), 128'({capb[r*14+c].row, capb[r*14+c].col}),
              128'({4'(r), 4'(c)}));
          chk($sformatf("t6_w%0d_win", r * 14 + c), 128'(capb[r*14+c].win), 128'(e));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
